// File: rtl/manchester_tx_ctrl_pkg.sv
// Shared types and line-coding constants for the Manchester transmit path.
package manchester_pkg;

    // Frame sequencing states of the transmit controller.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        TRAILER  = 2'd3
    } tx_state_t;

    // Symbol halves, written {first half, second half}.
    localparam logic [1:0] SYM_ONE   = 2'b01;
    localparam logic [1:0] SYM_ZERO  = 2'b10;

    // Level driven on the line when no symbol is being sent.
    localparam logic       LINE_IDLE = 1'b0;

    // Line level for one half of the symbol that encodes data_bit.
    function automatic logic sym_half(input logic data_bit, input logic second_half);
        logic [1:0] sym;
        sym = data_bit ? SYM_ONE : SYM_ZERO;
        return second_half ? sym[0] : sym[1];
    endfunction

endpackage

// File: rtl/manchester_tx_ctrl_if.sv
// Byte stream (valid/ready) feeding the Manchester transmit controller.
interface manchester_tx_ctrl_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_ready;

    // Byte producer side.
    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    // Byte consumer side (the transmit controller).
    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/manchester_tx_ctrl_baud_gen.sv
// Half-bit timebase: loadable down-counter that marks the last cycle of each
// half-bit and tracks whether the current half is the first or second one.
module manchester_baud_gen #(
    parameter int HALF_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [HALF_W-1:0] period,
    output logic              half_tick,
    output logic              phase
);

    logic [HALF_W-1:0] period_q;
    logic [HALF_W-1:0] cnt_reg;
    logic              phase_reg;

    // A half ends in the cycle where the counter has run down to zero.
    // A start in the same cycle restarts the timebase instead.
    assign half_tick = ena & ~start & (cnt_reg == '0);
    assign phase     = phase_reg;

    // Period is captured only at frame start so mid-frame changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (ena) begin
            if (start) begin
                period_q  <= period;
                cnt_reg   <= period;
                phase_reg <= 1'b0;
            end else if (cnt_reg == '0) begin
                cnt_reg   <= period_q;
                phase_reg <= ~phase_reg;
            end else begin
                cnt_reg   <= cnt_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/manchester_tx_ctrl.sv
// Frame-level Manchester transmitter: preamble, MSB-first data bytes taken
// from a valid/ready stream, then a low trailer. Owns line enable and status.
module manchester_tx_ctrl
    import manchester_pkg::*;
#(
    parameter int HALF_W        = 8,
    parameter int PREAMBLE_BITS = 8,
    parameter int TRAILER_BITS  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [HALF_W-1:0]   half_period,
    manchester_tx_ctrl_if.slave s_if,
    output logic                tx_line,
    output logic                tx_oe,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int SEQ_W = $clog2(PREAMBLE_BITS + TRAILER_BITS + 1);
    localparam logic [SEQ_W-1:0] PRE_LAST = SEQ_W'(PREAMBLE_BITS - 1);
    localparam logic [SEQ_W-1:0] TRL_LAST = SEQ_W'(TRAILER_BITS - 1);

    tx_state_t        state_reg;
    logic [7:0]       hold_data_reg;
    logic             hold_last_reg;
    logic             hold_valid_reg;
    logic [7:0]       shift_reg;
    logic             cur_last_reg;
    logic [2:0]       bit_cnt_reg;
    logic [SEQ_W-1:0] seq_cnt_reg;
    logic             aborted_reg;
    logic             tx_line_reg;
    logic             tx_oe_reg;
    logic             done_reg;
    logic             err_reg;

    logic             accept;
    logic             start;
    logic             half_tick;
    logic             phase;
    logic             byte_end;
    logic             bypass;
    logic             pre_bit;

    // Hold register is the only buffer; nothing is taken during the trailer.
    assign s_if.s_ready = ena & ~hold_valid_reg & (state_reg != TRAILER);
    assign accept       = s_if.s_valid & s_if.s_ready;

    // A frame starts from IDLE on a fresh handshake, or from a byte that was
    // accepted during the tail of the previous frame and is still held.
    assign start    = ena & (state_reg == IDLE) & (hold_valid_reg | accept);

    // Last cycle of the second half of bit 0 of the byte being shifted.
    assign byte_end = (state_reg == DATA) & half_tick & phase & (bit_cnt_reg == 3'd7);

    // Handshake on a byte boundary with nothing held goes straight to the shifter.
    assign bypass   = byte_end & ~cur_last_reg & ~hold_valid_reg & accept;

    // Preamble alternates 1,0,1,0,... starting with a 1 at count 0.
    assign pre_bit  = ~seq_cnt_reg[0];

    assign tx_line  = tx_line_reg;
    assign tx_oe    = tx_oe_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign err      = err_reg;

    manchester_baud_gen #(
        .HALF_W (HALF_W)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .period    (half_period),
        .half_tick (half_tick),
        .phase     (phase)
    );

    // Frame sequencer, hold register, shifter and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_data_reg  <= '0;
            hold_last_reg  <= 1'b0;
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            cur_last_reg   <= 1'b0;
            bit_cnt_reg    <= '0;
            seq_cnt_reg    <= '0;
            aborted_reg    <= 1'b0;
            tx_line_reg    <= LINE_IDLE;
            tx_oe_reg      <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else if (ena) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            // Ordinary handshakes fill the hold register; later loads in
            // this block may empty it again in the same cycle.
            if (accept && !bypass) begin
                hold_data_reg  <= s_if.s_data;
                hold_last_reg  <= s_if.s_last;
                hold_valid_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= PREAMBLE;
                        seq_cnt_reg <= '0;
                        aborted_reg <= 1'b0;
                        tx_oe_reg   <= 1'b1;
                        tx_line_reg <= sym_half(1'b1, 1'b0);
                    end
                end

                PREAMBLE: begin
                    if (half_tick) begin
                        if (!phase) begin
                            tx_line_reg <= sym_half(pre_bit, 1'b1);
                        end else if (seq_cnt_reg == PRE_LAST) begin
                            // Hold is always full here: it was loaded at frame start.
                            state_reg      <= DATA;
                            shift_reg      <= hold_data_reg;
                            cur_last_reg   <= hold_last_reg;
                            hold_valid_reg <= 1'b0;
                            bit_cnt_reg    <= '0;
                            tx_line_reg    <= sym_half(hold_data_reg[7], 1'b0);
                        end else begin
                            seq_cnt_reg <= seq_cnt_reg + 1'b1;
                            tx_line_reg <= sym_half(~pre_bit, 1'b0);
                        end
                    end
                end

                DATA: begin
                    if (half_tick) begin
                        if (!phase) begin
                            tx_line_reg <= sym_half(shift_reg[7], 1'b1);
                        end else if (!byte_end) begin
                            shift_reg   <= {shift_reg[6:0], 1'b0};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            tx_line_reg <= sym_half(shift_reg[6], 1'b0);
                        end else if (cur_last_reg) begin
                            state_reg   <= TRAILER;
                            seq_cnt_reg <= '0;
                            tx_line_reg <= LINE_IDLE;
                        end else if (hold_valid_reg) begin
                            shift_reg      <= hold_data_reg;
                            cur_last_reg   <= hold_last_reg;
                            hold_valid_reg <= 1'b0;
                            bit_cnt_reg    <= '0;
                            tx_line_reg    <= sym_half(hold_data_reg[7], 1'b0);
                        end else if (bypass) begin
                            shift_reg    <= s_if.s_data;
                            cur_last_reg <= s_if.s_last;
                            bit_cnt_reg  <= '0;
                            tx_line_reg  <= sym_half(s_if.s_data[7], 1'b0);
                        end else begin
                            // Underrun: close the frame early and flag it.
                            err_reg     <= 1'b1;
                            aborted_reg <= 1'b1;
                            state_reg   <= TRAILER;
                            seq_cnt_reg <= '0;
                            tx_line_reg <= LINE_IDLE;
                        end
                    end
                end

                TRAILER: begin
                    tx_line_reg <= LINE_IDLE;
                    if (half_tick && phase) begin
                        if (seq_cnt_reg == TRL_LAST) begin
                            state_reg <= IDLE;
                            tx_oe_reg <= 1'b0;
                            done_reg  <= ~aborted_reg;
                        end else begin
                            seq_cnt_reg <= seq_cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
